// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command encoder: FSM state encoding and
// protocol constants.
package sump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CODE,
    DATA,
    GAP,
    RSTSEQ
  } sump_state_t;

  localparam int unsigned SUMP_LONG_BIT  = 7;
  localparam logic [7:0]  SUMP_CMD_RESET = 8'h00;
  localparam int unsigned RST_SEQ_LEN    = 5;

endpackage

// File: rtl/sump_cmd_encoder.sv
// Serialises SUMP commands (1-byte short, 5-byte long) onto a UART TXD byte stream.
// The optional SUMP reset sequence (five 8'h00 bytes) exists only with SUMP_ENC_RESET_SEQ_EN.
module sump_cmd_encoder
  import sump_pkg::*;
#(
  parameter int unsigned BN_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] cmd_data,
  input  logic        rst_req,
  output logic        str_txd_tvalid,
  output logic [7:0]  str_txd_tdata,
  input  logic        str_txd_tready,
  output logic        busy,
  output logic [15:0] cnt_cmd
);

  localparam bit         GAP_EN   = (BN_GAP > 0);
  localparam logic [7:0] GAP_LOAD = GAP_EN ? 8'(BN_GAP - 1) : 8'h00;

  sump_state_t state, state_d;
  sump_state_t ret_q, ret_d;
  sump_state_t after;

  logic [7:0]  code_q;
  logic [31:0] data_q;
  logic [1:0]  idx_q;
  logic [7:0]  gap_q;
  logic [15:0] cnt_q;
  logic        rst_pend;
  logic        accept;
  logic        xfer;
  logic        last;

`ifdef SUMP_ENC_RESET_SEQ_EN
  logic       pend_q;
  logic [2:0] rs_q;

  // A request in the current cycle already counts as pending so it beats a
  // simultaneous command offer in IDLE.
  assign rst_pend = pend_q | rst_req;
`else
  logic unused_rst_req;

  assign unused_rst_req = rst_req;
  assign rst_pend       = 1'b0;
`endif

  assign cmd_tready     = (state == IDLE) && !rst_pend;
  assign accept         = cmd_tvalid && cmd_tready;
  assign str_txd_tvalid = (state == CODE) || (state == DATA) || (state == RSTSEQ);
  assign xfer           = str_txd_tvalid && str_txd_tready;
  assign busy           = (state != IDLE) || rst_pend;
  assign cnt_cmd        = cnt_q;

  always_comb begin
    str_txd_tdata = 8'h00;
    case (state)
      CODE: str_txd_tdata = code_q;
      DATA: begin
        case (idx_q)
          2'd0:    str_txd_tdata = data_q[7:0];
          2'd1:    str_txd_tdata = data_q[15:8];
          2'd2:    str_txd_tdata = data_q[23:16];
          default: str_txd_tdata = data_q[31:24];
        endcase
      end
      RSTSEQ:  str_txd_tdata = SUMP_CMD_RESET;
      default: str_txd_tdata = 8'h00;
    endcase
  end

  // 'after' is where the FSM heads once the current byte is taken; with a
  // gap configured it is parked in ret_q while GAP counts down.
  always_comb begin
    state_d = state;
    ret_d   = ret_q;
    after   = state;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_pend) begin
          state_d = RSTSEQ;
        end else if (accept) begin
          state_d = CODE;
        end
      end
      CODE: begin
        if (code_q[SUMP_LONG_BIT]) begin
          after = DATA;
        end else begin
          after = IDLE;
          last  = xfer;
        end
      end
      DATA: begin
        if (idx_q == 2'd3) begin
          after = IDLE;
          last  = xfer;
        end
      end
`ifdef SUMP_ENC_RESET_SEQ_EN
      RSTSEQ: begin
        if (rs_q == 3'(RST_SEQ_LEN - 1)) begin
          after = IDLE;
        end
      end
`endif
      GAP: begin
        if (gap_q == '0) begin
          state_d = ret_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      if (GAP_EN) begin
        state_d = GAP;
        ret_d   = after;
      end else begin
        state_d = after;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ret_q  <= IDLE;
      code_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
      gap_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_d;
      ret_q <= ret_d;
      if (accept) begin
        code_q <= cmd_code;
        data_q <= cmd_data;
        idx_q  <= '0;
      end else if ((state == DATA) && xfer) begin
        idx_q <= idx_q + 2'd1;
      end
      if (xfer && GAP_EN) begin
        gap_q <= GAP_LOAD;
      end else if ((state == GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - 8'd1;
      end
      if (last) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

`ifdef SUMP_ENC_RESET_SEQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      rs_q   <= '0;
    end else begin
      if ((state == IDLE) && rst_pend) begin
        pend_q <= 1'b0;
        rs_q   <= '0;
      end else begin
        pend_q <= pend_q | rst_req;
        if ((state == RSTSEQ) && xfer) begin
          rs_q <= rs_q + 3'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/sump_cmd_encoder.md
SUMP_CMD_ENCODER -- requirements
Module: sump_cmd_encoder

Interface
REQ-001 SHALL have parameter BN_GAP, default 0: idle cycles inserted between consecutive output bytes (0..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_tvalid  input  1  command offered.
REQ-005 SHALL have port cmd_tready  output  1  command accepted when high with cmd_tvalid.
REQ-006 SHALL have port cmd_code  input  8  SUMP opcode.
REQ-007 SHALL have port cmd_data  input  32  long-command argument.
REQ-008 SHALL have port rst_req  input  1  one-cycle request for a SUMP reset sequence.
REQ-009 SHALL have port str_txd_tvalid  output  1  byte valid towards the UART TXD stream.
REQ-010 SHALL have port str_txd_tdata  output  8  byte.
REQ-011 SHALL have port str_txd_tready  input  1  UART accepts byte.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE or a reset sequence is pending.
REQ-013 SHALL have port cnt_cmd  output  16  number of commands fully transmitted.

Function
REQ-014 SHALL use FSM states IDLE, CODE, DATA, GAP, RSTSEQ.
REQ-015 SHALL drive cmd_tready = (state==IDLE) && !rst_pend.
REQ-016 SHALL capture cmd_code/cmd_data on cmd_tvalid&&cmd_tready and enter CODE; str_txd_tvalid high with the opcode byte on the next cycle (latency 1).
REQ-017 SHALL hold str_txd_tdata and str_txd_tvalid stable until str_txd_tready; byte transfer = tvalid&&tready.
REQ-018 SHALL treat cmd_code[7]==0 as short (1 byte) and cmd_code[7]==1 as long (5 bytes: opcode, then cmd_data[7:0], [15:8], [23:16], [31:24]).
REQ-019 SHALL use a 2-bit byte index in DATA; index 3 transfer ends the command.
REQ-020 SHALL, when BN_GAP>0, enter GAP for exactly BN_GAP cycles after each byte transfer with str_txd_tvalid low, then resume; BN_GAP==0 transfers back-to-back bytes.
REQ-021 SHALL return to IDLE the cycle after the final byte transfer (after the trailing GAP if BN_GAP>0); minimum one IDLE cycle between commands.
REQ-022 SHALL increment cnt_cmd on final byte transfer of each command; 16'hFFFF wraps to 0; reset sequences not counted.
REQ-023 SHALL latch rst_req into rst_pend at any state; repeated requests while pending merge into one sequence.
REQ-024 SHALL start a pending reset sequence only from IDLE (never mid-command); rst_req and cmd_tvalid in the same IDLE cycle: reset sequence wins, command waits.
REQ-025 SHALL clear rst_pend on entering RSTSEQ.
REQ-026 SHALL ignore str_txd_tready while str_txd_tvalid is low.

Reset
REQ-027 SHALL on rst low force state=IDLE, str_txd_tvalid=0, str_txd_tdata=8'h00, cnt_cmd=0, rst_pend=0, busy=0, byte index=0, gap counter=0.
REQ-028 SHALL abandon any partly sent command on reset assertion; no byte resumes after deassertion.
REQ-029 SHALL assert cmd_tready=1 in the first cycle after reset release.

Configuration
REQ-030 SHALL compile the reset-sequence feature only with macro SUMP_ENC_RESET_SEQ_EN.
REQ-031 SHALL with SUMP_ENC_RESET_SEQ_EN defined: RSTSEQ emits five 8'h00 bytes (same handshake and GAP rules), then IDLE.
REQ-032 SHALL without the macro: rst_req port present but ignored, rst_pend constant 0, RSTSEQ unreachable.

Structure
REQ-033 SHALL place state enum, SUMP_LONG_BIT=7, SUMP_CMD_RESET=8'h00 and RST_SEQ_LEN=5 in shared package sump_pkg.
REQ-034 SHALL be one flat module; no sub-module is natural.

Verification
REQ-035 SHALL check short command: code 8'h01, tready always 1 -> single byte 8'h01 one cycle after accept; cnt_cmd 0->1.
REQ-036 SHALL check long command: code 8'hC0, data 32'h0004_0003 -> bytes C0,03,00,04,00 consecutive; cnt_cmd +1.
REQ-037 SHALL check backpressure: tready low 3 cycles on byte 2 of 8'h80/32'hAABBCCDD -> tdata held 8'hCC, full order 80,DD,CC,BB,AA.
REQ-038 SHALL check reset sequence (macro on): rst_req with cmd_tvalid in IDLE -> five 8'h00 first, then the command; cnt_cmd +1 only.
REQ-039 SHALL check BN_GAP=2: long command -> exactly 2 invalid cycles between each byte; reset mid-DATA -> tvalid 0 immediately, cnt_cmd 0.
